// File: rtl/j1_io_responder_pkg.sv
// j1_io_pkg: shared address decode bits, IRQ_CTRL field layout and pending-bit indices.
// Build option: IO_GPIO_IRQ_EN enables the GPIO edge interrupt and its enable bit.
package j1_io_pkg;
   localparam int IO_GPIO_OUT_BIT     = 8;
   localparam int IO_GPIO_IN_BIT      = 9;
   localparam int IO_TIMER_RELOAD_BIT = 10;
   localparam int IO_TIMER_COUNT_BIT  = 11;
   localparam int IO_IRQ_CTRL_BIT     = 12;
   localparam int IRQ_EN_LSB   = 0;
   localparam int IRQ_PEND_LSB = 8;
   typedef enum logic {IRQ_TIMER = 1'b0, IRQ_GPIO = 1'b1} irq_idx_e;
   // Interrupt sources that physically exist in this build.
`ifdef IO_GPIO_IRQ_EN
   localparam logic [1:0] IRQ_MASK = 2'b11;
`else
   localparam logic [1:0] IRQ_MASK = 2'b01;
`endif
endpackage

// File: rtl/j1_io_responder_if.sv
// j1_io_responder_if: J1 IO bus between core (master) and responder (slave).
// Signals: io_rd/io_wr strobes, mem_addr, dout (write data), io_din (read data), interrupt_request.
interface j1_io_responder_if;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] mem_addr;
   logic [15:0] dout;
   logic [15:0] io_din;
   logic        interrupt_request;
   modport master (output io_rd, io_wr, mem_addr, dout, input io_din, interrupt_request);
   modport slave  (input io_rd, io_wr, mem_addr, dout, output io_din, interrupt_request);
endinterface

// File: rtl/j1_io_responder_timer.sv
// j1_io_timer: free-running prescaler plus 16-bit reload down counter.
// Ports: clk, reset, load/load_data (software load of count), reload (current reload value),
//        count (current count), expire (one-cycle pulse when a tick finds count at 0).
module j1_io_timer #(
   parameter int PRESCALE = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_data,
   input  logic [15:0] reload,
   output logic [15:0] count,
   output logic        expire
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   count_q, count_d;
   logic          tick;
   always_comb begin
      tick    = pre_q == PW'(PRESCALE - 1);
      pre_d   = tick ? '0 : pre_q + 1'b1;
      expire  = tick && count_q == '0 && reload != '0;
      // A zero reload freezes the counter; a software load always wins.
      count_d = load ? load_data
              : (tick && reload != '0) ? (count_q == '0 ? reload : count_q - 1'b1)
              : count_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q   <= '0;
         count_q <= '0;
      end else begin
         pre_q   <= pre_d;
         count_q <= count_d;
      end
   end
   assign count = count_q;
endmodule

// File: rtl/j1_io_responder.sv
// j1_io_responder: J1 IO-bus responder with GPIO out/in, prescaled reload timer and IRQ control.
// Ports: clk, reset (sync, active-high), bus (IO bus slave), gpio_out (register), gpio_in (async pins).
// Build option: IO_GPIO_IRQ_EN adds a rising-edge interrupt on gpio_in[0].
module j1_io_responder
   import j1_io_pkg::*;
#(
   parameter int GPIO_W   = 8,
   parameter int PRESCALE = 48
) (
   input  logic              clk,
   input  logic              reset,
   j1_io_responder_if.slave  bus,
   output logic [GPIO_W-1:0] gpio_out,
   input  logic [GPIO_W-1:0] gpio_in
);
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
   logic [GPIO_W-1:0] sync1_q, sync2_q;
   logic [15:0]       reload_q, reload_d;
   logic [15:0]       io_din_q, io_din_d;
   logic [1:0]        enable_q, enable_d;
   logic [1:0]        pending_q, pending_d;
   logic              irq_q, irq_d;
   logic [1:0]        irq_set, irq_clr;
   logic [15:0]       rdata, irq_ctrl, count;
   logic              wr_gpio, wr_reload, wr_irq, expire, gpio_edge;
   logic              unused_ok;
   assign unused_ok = &{1'b0, bus.mem_addr[15:13], bus.mem_addr[7:0], bus.dout};
   j1_io_timer #(.PRESCALE(PRESCALE)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (wr_reload),
      .load_data (bus.dout),
      .reload    (reload_q),
      .count     (count),
      .expire    (expire)
   );
`ifdef IO_GPIO_IRQ_EN
   logic gpio_prev_q;
   always_ff @(posedge clk) gpio_prev_q <= reset ? 1'b0 : sync2_q[0];
   assign gpio_edge = sync2_q[0] & ~gpio_prev_q;
`else
   assign gpio_edge = 1'b0;
`endif
   always_comb begin
      wr_gpio    = bus.io_wr & bus.mem_addr[IO_GPIO_OUT_BIT];
      wr_reload  = bus.io_wr & bus.mem_addr[IO_TIMER_RELOAD_BIT];
      wr_irq     = bus.io_wr & bus.mem_addr[IO_IRQ_CTRL_BIT];
      irq_ctrl   = {6'b0, pending_q, 6'b0, enable_q};
      // Selected sources are OR-ed so multi-bit addresses read the union.
      rdata      = (bus.mem_addr[IO_GPIO_OUT_BIT]     ? 16'(gpio_out_q) : '0)
                 | (bus.mem_addr[IO_GPIO_IN_BIT]      ? 16'(sync2_q)    : '0)
                 | (bus.mem_addr[IO_TIMER_RELOAD_BIT] ? reload_q        : '0)
                 | (bus.mem_addr[IO_TIMER_COUNT_BIT]  ? count           : '0)
                 | (bus.mem_addr[IO_IRQ_CTRL_BIT]     ? irq_ctrl        : '0);
      irq_set            = '0;
      irq_set[IRQ_TIMER] = expire;
      irq_set[IRQ_GPIO]  = gpio_edge;
      irq_clr    = wr_irq ? bus.dout[IRQ_PEND_LSB +: 2] : 2'b00;
      // Set is OR-ed after the clear so a simultaneous event keeps the bit.
      pending_d  = ((pending_q & ~irq_clr) | irq_set) & IRQ_MASK;
      enable_d   = wr_irq ? bus.dout[IRQ_EN_LSB +: 2] & IRQ_MASK : enable_q;
      irq_d      = |(pending_q & enable_q);
      gpio_out_d = wr_gpio ? bus.dout[GPIO_W-1:0] : gpio_out_q;
      reload_d   = wr_reload ? bus.dout : reload_q;
      io_din_d   = bus.io_rd ? rdata : io_din_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         gpio_out_q <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         reload_q   <= '0;
         io_din_q   <= '0;
         enable_q   <= '0;
         pending_q  <= '0;
         irq_q      <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         sync1_q    <= gpio_in;
         sync2_q    <= sync1_q;
         reload_q   <= reload_d;
         io_din_q   <= io_din_d;
         enable_q   <= enable_d;
         pending_q  <= pending_d;
         irq_q      <= irq_d;
      end
   end
   assign bus.io_din            = io_din_q;
   assign bus.interrupt_request = irq_q;
   assign gpio_out              = gpio_out_q;
endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: randomized and directed checks of j1_io_responder against a behavioural model.
module tb_j1_io_responder;
   localparam int P  = 4;
   localparam int GW = 8;
`ifdef IO_GPIO_IRQ_EN
   localparam logic [1:0] MMASK = 2'b11;
`else
   localparam logic [1:0] MMASK = 2'b01;
`endif
   logic clk = 1'b0;
   logic reset;
   logic [GW-1:0] gpio_out, gpio_in;
   int vectors = 0;
   int miscompares = 0;
   j1_io_responder_if bus();
   j1_io_responder #(.GPIO_W(GW), .PRESCALE(P)) dut (
      .clk(clk), .reset(reset), .bus(bus), .gpio_out(gpio_out), .gpio_in(gpio_in)
   );
   always #5 clk = ~clk;
   // Behavioural model state
   logic [GW-1:0] m_gpio, m_s1, m_s2;
   logic          m_prev, m_irq;
   logic [15:0]   m_rel, m_cnt, m_din;
   logic [1:0]    m_en, m_pend;
   int            m_cyc;
   function automatic logic [15:0] m_read(input logic [15:0] a);
      logic [15:0] r;
      r = 16'h0;
      if (a[8])  r |= 16'(m_gpio);
      if (a[9])  r |= 16'(m_s2);
      if (a[10]) r |= m_rel;
      if (a[11]) r |= m_cnt;
      if (a[12]) r |= {6'b0, m_pend, 6'b0, m_en};
      return r;
   endfunction
   function automatic logic m_expire_now();
      return (m_cyc % P) == P - 1 && m_cnt == 16'h0 && m_rel != 16'h0;
   endfunction
   // One clock: model computes the next state from the inputs now on the bus.
   task automatic cycle();
      logic [15:0] a, d, n_din, n_cnt, n_rel;
      logic [GW-1:0] n_gpio;
      logic [1:0] n_pend, n_en, clr, set;
      logic n_irq, w;
      a = bus.mem_addr;
      d = bus.dout;
      w = bus.io_wr;
      n_din  = bus.io_rd ? m_read(a) : m_din;
      n_gpio = (w && a[8]) ? d[GW-1:0] : m_gpio;
      n_rel  = (w && a[10]) ? d : m_rel;
      if (w && a[10]) n_cnt = d;
      else if ((m_cyc % P) == P - 1 && m_rel != 0) n_cnt = (m_cnt == 0) ? m_rel : m_cnt - 16'd1;
      else n_cnt = m_cnt;
      clr    = (w && a[12]) ? d[9:8] : 2'b00;
      set    = {m_s2[0] & ~m_prev, m_expire_now()};
      n_pend = ((m_pend & ~clr) | set) & MMASK;
      n_en   = (w && a[12]) ? d[1:0] & MMASK : m_en;
      n_irq  = |(m_pend & m_en);
      @(posedge clk);
      @(negedge clk);
      if (reset) begin
         m_gpio = 0; m_s1 = 0; m_s2 = 0; m_prev = 0; m_irq = 0; m_rel = 0; m_cnt = 0;
         m_din = 0; m_en = 0; m_pend = 0; m_cyc = 0;
      end else begin
         m_prev = m_s2[0]; m_s2 = m_s1; m_s1 = gpio_in;
         m_gpio = n_gpio; m_rel = n_rel; m_cnt = n_cnt; m_din = n_din;
         m_en = n_en; m_pend = n_pend; m_irq = n_irq; m_cyc++;
      end
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask
   task automatic io_write(input logic [15:0] a, input logic [15:0] d);
      bus.io_wr = 1'b1; bus.mem_addr = a; bus.dout = d;
      cycle();
      bus.io_wr = 1'b0;
   endtask
   task automatic io_read(input logic [15:0] a);
      bus.io_rd = 1'b1; bus.mem_addr = a;
      cycle();
      bus.io_rd = 1'b0;
   endtask
   task automatic test_reset();
      logic [15:0] addrs [5] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000};
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      foreach (addrs[i]) begin
         io_read(addrs[i]);
         vectors++;
         if (bus.io_din !== 16'h0 || bus.interrupt_request !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read addr=%h io_din=%h irq=%b expected io_din=0000 irq=0", addrs[i], bus.io_din, bus.interrupt_request);
         end
      end
   endtask
   task automatic test_gpio();
      io_write(16'h0100, 16'h00A5);
      vectors++;
      if (gpio_out !== 8'hA5) begin miscompares++; $display("FAIL gpio_out got=%h expected=a5", gpio_out); end
      io_read(16'h0100);
      vectors++;
      if (bus.io_din !== 16'h00A5) begin miscompares++; $display("FAIL gpio_read got=%h expected=00a5", bus.io_din); end
      gpio_in = 8'h3C;
      idle(3);
      io_read(16'h0300);
      vectors++;
      if (bus.io_din !== 16'h00BD) begin miscompares++; $display("FAIL gpio_or_read got=%h expected=00bd", bus.io_din); end
      bus.io_rd = 1'b1;
      io_write(16'h0100, 16'h005A);
      bus.io_rd = 1'b0;
      vectors++;
      if (bus.io_din !== 16'h00A5 || gpio_out !== 8'h5A) begin
         miscompares++;
         $display("FAIL rd_wr_same io_din=%h gpio_out=%h expected io_din=00a5 gpio_out=5a", bus.io_din, gpio_out);
      end
   endtask
   task automatic test_timer();
      int t1, t2;
      io_write(16'h0400, 16'h0002);
      io_write(16'h1000, 16'h0001);
      for (int i = 0; i < 60 && !bus.interrupt_request; i++) cycle();
      vectors++;
      if (bus.interrupt_request !== 1'b1 || m_irq !== 1'b1) begin
         miscompares++; $display("FAIL timer_first_irq irq=%b model=%b expected 1", bus.interrupt_request, m_irq);
      end
      t1 = m_cyc;
      io_write(16'h1000, 16'h0101);
      cycle();
      vectors++;
      if (bus.interrupt_request !== 1'b0) begin miscompares++; $display("FAIL timer_irq_clear irq=%b expected 0", bus.interrupt_request); end
      for (int i = 0; i < 60 && !bus.interrupt_request; i++) cycle();
      t2 = m_cyc;
      vectors++;
      if (t2 - t1 != 3 * P || bus.interrupt_request !== 1'b1) begin
         miscompares++; $display("FAIL timer_period got=%0d cycles irq=%b expected=%0d irq=1", t2 - t1, bus.interrupt_request, 3 * P);
      end
   endtask
   task automatic test_collision();
      for (int i = 0; i < 60 && !m_expire_now(); i++) cycle();
      io_write(16'h1000, 16'h0101);
      vectors++;
      if (bus.interrupt_request !== 1'b1) begin miscompares++; $display("FAIL collide_irq got=%b expected 1", bus.interrupt_request); end
      io_read(16'h1000);
      vectors++;
      if (bus.io_din !== 16'h0101 || bus.interrupt_request !== 1'b1) begin
         miscompares++; $display("FAIL collide_pending io_din=%h irq=%b expected 0101 irq=1", bus.io_din, bus.interrupt_request);
      end
   endtask
   task automatic test_stop();
      io_write(16'h0400, 16'h0000);
      io_write(16'h1000, 16'h0101);
      idle(100);
      io_read(16'h0800);
      vectors++;
      if (bus.io_din !== 16'h0000) begin miscompares++; $display("FAIL stop_count got=%h expected 0000", bus.io_din); end
      io_read(16'h1000);
      vectors++;
      if (bus.io_din !== 16'h0001 || bus.interrupt_request !== 1'b0) begin
         miscompares++; $display("FAIL stop_pending io_din=%h irq=%b expected 0001 irq=0", bus.io_din, bus.interrupt_request);
      end
   endtask
   task automatic test_reset_mid();
      io_write(16'h0400, 16'h0005);
      io_write(16'h1000, 16'h0001);
      idle(7);
      reset = 1'b1;
      io_write(16'h0100, 16'h00FF);
      reset = 1'b0;
      vectors++;
      if (gpio_out !== 8'h00 || bus.io_din !== 16'h0 || bus.interrupt_request !== 1'b0) begin
         miscompares++; $display("FAIL reset_mid gpio=%h io_din=%h irq=%b expected all 0", gpio_out, bus.io_din, bus.interrupt_request);
      end
      io_read(16'h1C00);
      vectors++;
      if (bus.io_din !== 16'h0) begin miscompares++; $display("FAIL reset_mid_regs got=%h expected 0000", bus.io_din); end
   endtask
   task automatic test_gpio_irq();
      gpio_in = 8'h00;
      idle(4);
`ifdef IO_GPIO_IRQ_EN
      io_write(16'h1000, 16'h0002);
      gpio_in = 8'h01;
      idle(4);
      vectors++;
      if (bus.interrupt_request !== 1'b1) begin miscompares++; $display("FAIL gpio_irq got=%b expected 1", bus.interrupt_request); end
      io_read(16'h1000);
      vectors++;
      if (bus.io_din !== 16'h0202) begin miscompares++; $display("FAIL gpio_irq_pending got=%h expected 0202", bus.io_din); end
      io_write(16'h1000, 16'h0202);
      idle(10);
      io_read(16'h1000);
      vectors++;
      if (bus.io_din !== 16'h0002 || bus.interrupt_request !== 1'b0) begin
         miscompares++; $display("FAIL gpio_irq_hold io_din=%h irq=%b expected 0002 irq=0", bus.io_din, bus.interrupt_request);
      end
`else
      io_write(16'h1000, 16'h0002);
      gpio_in = 8'h01;
      idle(4);
      io_read(16'h1000);
      vectors++;
      if (bus.io_din !== 16'h0000 || bus.interrupt_request !== 1'b0) begin
         miscompares++; $display("FAIL gpio_irq_absent io_din=%h irq=%b expected 0000 irq=0", bus.io_din, bus.interrupt_request);
      end
`endif
   endtask
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.io_rd = 1'($urandom);
         bus.io_wr = 1'($urandom);
         bus.mem_addr = {3'b000, 5'($urandom), 8'($urandom)};
         bus.dout = ($urandom_range(0, 1) == 1) ? 16'($urandom) & 16'h0307 : 16'($urandom);
         if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
         reset = ($urandom_range(0, 99) == 0);
         cycle();
         vectors++;
         if (bus.io_din !== m_din || bus.interrupt_request !== m_irq || gpio_out !== m_gpio) begin
            miscompares++;
            $display("FAIL random[%0d] io_din=%h irq=%b gpio=%h expected io_din=%h irq=%b gpio=%h",
                     i, bus.io_din, bus.interrupt_request, gpio_out, m_din, m_irq, m_gpio);
         end
      end
      bus.io_rd = 1'b0; bus.io_wr = 1'b0; reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; gpio_in = '0;
      bus.io_rd = 1'b0; bus.io_wr = 1'b0; bus.mem_addr = '0; bus.dout = '0;
      test_reset();
      test_gpio();
      test_timer();
      test_collision();
      test_stop();
      test_reset_mid();
      test_gpio_irq();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
